// File: rtl/dm_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_unit_pkg
// Description : Shared store-type codes and the store-buffer entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_store_unit_pkg;

    // 2'b11 is not listed here; the alignment logic treats it as a word store
    localparam logic [1:0] DM_SW = 2'b00;
    localparam logic [1:0] DM_SH = 2'b01;
    localparam logic [1:0] DM_SB = 2'b10;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_entry_t;

endpackage : dm_store_unit_pkg
`default_nettype wire

// File: rtl/dm_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_unit_if
// Description : CPU store/load-lookup and data-memory write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_store_unit_if;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_misalign;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;

    modport master (
        output st_valid, st_type, st_addr, st_wdata, ld_valid, ld_addr, mem_ack,
        input  st_ready, st_misalign, ld_hazard, mem_req, mem_addr, mem_wdata,
               mem_be, empty
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_wdata, ld_valid, ld_addr, mem_ack,
        output st_ready, st_misalign, ld_hazard, mem_req, mem_addr, mem_wdata,
               mem_be, empty
    );
endinterface : dm_store_unit_if
`default_nettype wire

// File: rtl/dm_store_unit_st_align.sv
`default_nettype none
// ============================================================================
// Module      : st_align
// Description : Replicates store data onto byte lanes, builds byte enables
//               and flags misaligned addresses (purely combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module st_align
    import dm_store_unit_pkg::*;
(
    input  wire logic [1:0]  i_type,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_data,
    output logic      [3:0]  o_be,
    output logic             o_misalign
);

    always_comb begin
        o_data     = i_wdata;
        o_be       = 4'b1111;
        o_misalign = |i_addr_lo;
        case (i_type)
            DM_SH: begin
                o_data     = {2{i_wdata[15:0]}};
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            DM_SB: begin
                o_data     = {4{i_wdata[7:0]}};
                o_be       = 4'b0001 << i_addr_lo;
                o_misalign = 1'b0;
            end
            default: ;
        endcase
    end

endmodule : st_align
`default_nettype wire

// File: rtl/dm_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_unit
// Description : Store buffer: formats CPU stores into a FIFO and drains them
//               to data memory one request at a time; flags load hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_store_unit
    import dm_store_unit_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  wire logic        clk,
    input  wire logic        rst,
    dm_store_unit_if.slave   bus
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    st_entry_t            r_fifo [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   w_rd_next;
    logic [c_CNT_W-1:0]   r_count;
    state_e               r_state;
    state_e               w_state_nxt;
    logic                 w_load;
    st_entry_t            w_load_ent;
    st_entry_t            w_new;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [3:0]           r_mem_be;
    logic                 r_misalign;
    logic [31:0]          w_fmt_data;
    logic [3:0]           w_fmt_be;
    logic                 w_misalign;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_unused;

    st_align u_align (
        .i_type     (bus.st_type),
        .i_addr_lo  (bus.st_addr[1:0]),
        .i_wdata    (bus.st_wdata),
        .o_data     (w_fmt_data),
        .o_be       (w_fmt_be),
        .o_misalign (w_misalign)
    );

    assign w_new     = '{waddr: bus.st_addr[31:2], data: w_fmt_data, be: w_fmt_be};
    assign w_accept  = bus.st_valid & bus.st_ready;
    assign w_push    = w_accept & ~w_misalign;
    assign w_pop     = (r_state == S_BUSY) & bus.mem_ack;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_unused  = ^bus.ld_addr[1:0];

    // Next request is the entry behind the head, or the store arriving right
    // now when the head was the only entry (it is not in the array yet).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_ent  = r_fifo[r_rd_ptr];
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_BUSY;
                    w_load      = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_pop) begin
                    if (r_count == c_ONE) begin
                        if (w_push) begin
                            w_load     = 1'b1;
                            w_load_ent = w_new;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_load     = 1'b1;
                        w_load_ent = r_fifo[w_rd_next];
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_accept & w_misalign;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_load) begin
                r_mem_addr  <= {w_load_ent.waddr, 2'b00};
                r_mem_wdata <= w_load_ent.data;
                r_mem_be    <= w_load_ent.be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_new;
    end

    // Live entries are those within r_count slots of the head, modulo DEPTH.
    always_comb begin
        w_hit = w_push & (bus.st_addr[31:2] == bus.ld_addr[31:2]);
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, c_PTR_W'(i) - r_rd_ptr} < r_count) &&
                (r_fifo[i].waddr == bus.ld_addr[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign bus.st_ready    = (r_count != c_FULL);
    assign bus.st_misalign = r_misalign;
    assign bus.ld_hazard   = bus.ld_valid & w_hit;
    assign bus.mem_req     = (r_state == S_BUSY);
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_be      = r_mem_be;
    assign bus.empty       = (r_count == '0) && (r_state == S_IDLE);

endmodule : dm_store_unit
`default_nettype wire

// File: tb/tb_dm_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_store_unit
// Description : Directed bench for dm_store_unit with a write/misalign
//               scoreboard checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_store_unit;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    localparam logic [1:0] c_SW = 2'b00;
    localparam logic [1:0] c_SH = 2'b01;
    localparam logic [1:0] c_SB = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    wr_t  wr_q[$];
    int   mis_q[$];

    dm_store_unit_if bus ();

    dm_store_unit #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One-cycle store; expectation queued at issue time.
    task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                            input bit mis, input bit track,
                            input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb);
        bus.st_valid = 1'b1;
        bus.st_type  = t;
        bus.st_addr  = a;
        bus.st_wdata = d;
        if (mis) mis_q.push_back(cyc_n + 1);
        else if (track) wr_q.push_back('{a: ea, d: ed, be: eb});
        cyc();
        bus.st_valid = 1'b0;
    endtask

    // Monitor: every memory handshake and every misalign pulse is matched.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req && bus.mem_ack) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: actual=%h required=none", bus.mem_addr);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", bus.mem_addr, e.a);
                    chk("wr_data", bus.mem_wdata, e.d);
                    chk("wr_be", {28'd0, bus.mem_be}, {28'd0, e.be});
                end
            end
            if (bus.st_misalign || (mis_q.size() > 0 && mis_q[0] == cyc_n)) begin
                logic exp_m;
                exp_m = (mis_q.size() > 0 && mis_q[0] == cyc_n);
                if (exp_m) void'(mis_q.pop_front());
                chk("misalign_pulse", {31'd0, bus.st_misalign}, {31'd0, exp_m});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.st_valid = 1'b0;
        bus.st_type  = 2'b00;
        bus.st_addr  = '0;
        bus.st_wdata = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        // reset state
        chk("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        chk("rst_misalign", {31'd0, bus.st_misalign}, 32'd0);

        // SB at byte 3, ack with the first request
        do_store(c_SB, 32'h0000_1003, 32'h0000_00AB, 0, 1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        chk("sb_latency_n1", {31'd0, bus.mem_req}, 32'd0);
        cyc();
        chk("sb_req_n2", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        cyc();
        chk("sb_empty_after", {31'd0, bus.empty}, 32'd1);
        chk("sb_req_after", {31'd0, bus.mem_req}, 32'd0);

        // SH then SW with ack delayed three cycles
        do_store(c_SH, 32'h0000_2002, 32'h0000_1234, 0, 1, 32'h0000_2000, 32'h1234_1234, 4'b1100);
        do_store(c_SW, 32'h0000_2004, 32'hDEAD_BEEF, 0, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            chk("sh_hold_req", {31'd0, bus.mem_req}, 32'd1);
            chk("sh_hold_addr", bus.mem_addr, 32'h0000_2000);
            chk("sh_hold_data", bus.mem_wdata, 32'h1234_1234);
            chk("sh_hold_be", {28'd0, bus.mem_be}, 32'hC);
            cyc();
        end
        bus.mem_ack = 1'b1;
        cyc();
        chk("sw_next_req", {31'd0, bus.mem_req}, 32'd1);
        chk("sw_next_be", {28'd0, bus.mem_be}, 32'hF);
        cyc();
        bus.mem_ack = 1'b0;
        cyc();
        chk("shsw_empty", {31'd0, bus.empty}, 32'd1);

        // misaligned stores are dropped; type 2'b11 behaves as SW
        do_store(c_SW, 32'h0000_3001, 32'h1111_1111, 1, 0, '0, '0, '0);
        chk("sw_mis_pulse", {31'd0, bus.st_misalign}, 32'd1);
        cyc();
        chk("sw_mis_clear", {31'd0, bus.st_misalign}, 32'd0);
        chk("sw_mis_noreq", {31'd0, bus.mem_req}, 32'd0);
        chk("sw_mis_empty", {31'd0, bus.empty}, 32'd1);
        do_store(c_SH, 32'h0000_3001, 32'h2222_2222, 1, 0, '0, '0, '0);
        cyc();
        chk("sh_mis_noreq", {31'd0, bus.mem_req}, 32'd0);
        do_store(2'b11, 32'h0000_3002, 32'h3333_3333, 1, 0, '0, '0, '0);
        cyc();
        chk("t3_mis_empty", {31'd0, bus.empty}, 32'd1);

        // fill to DEPTH, reject the fifth, drain in order
        for (int k = 0; k < 4; k++)
            do_store(c_SW, 32'h0000_5000 + 32'(4 * k), 32'(k + 1), 0, 1,
                     32'h0000_5000 + 32'(4 * k), 32'(k + 1), 4'b1111);
        chk("full_ready", {31'd0, bus.st_ready}, 32'd0);
        do_store(c_SW, 32'h0000_5010, 32'h0000_0005, 0, 0, '0, '0, '0);
        chk("full_ready_hold", {31'd0, bus.st_ready}, 32'd0);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        chk("full_ready_back", {31'd0, bus.st_ready}, 32'd1);
        chk("full_next_addr", bus.mem_addr, 32'h0000_5004);
        bus.mem_ack = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.mem_ack = 1'b0;
        cyc();
        chk("full_drained", {31'd0, bus.empty}, 32'd1);

        // simultaneous push and pop with a single entry
        do_store(c_SW, 32'h0000_8000, 32'h1111_1111, 0, 1, 32'h0000_8000, 32'h1111_1111, 4'b1111);
        cyc();
        bus.mem_ack = 1'b1;
        do_store(c_SW, 32'h0000_8004, 32'h2222_2222, 0, 1, 32'h0000_8004, 32'h2222_2222, 4'b1111);
        chk("pp_req", {31'd0, bus.mem_req}, 32'd1);
        chk("pp_addr", bus.mem_addr, 32'h0000_8004);
        cyc();
        bus.mem_ack = 1'b0;
        cyc();
        chk("pp_empty", {31'd0, bus.empty}, 32'd1);

        // load hazard against pending and incoming stores
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_4000;
        bus.st_valid = 1'b1;
        bus.st_type  = c_SW;
        bus.st_addr  = 32'h0000_4000;
        bus.st_wdata = 32'h4444_4444;
        wr_q.push_back('{a: 32'h0000_4000, d: 32'h4444_4444, be: 4'b1111});
        #1;
        chk("hz_incoming", {31'd0, bus.ld_hazard}, 32'd1);
        cyc();
        bus.st_valid = 1'b0;
        bus.ld_addr  = 32'h0000_4002;
        #1;
        chk("hz_same_word", {31'd0, bus.ld_hazard}, 32'd1);
        bus.ld_addr  = 32'h0000_4004;
        #1;
        chk("hz_other_word", {31'd0, bus.ld_hazard}, 32'd0);
        cyc();
        bus.ld_addr  = 32'h0000_4000;
        #1;
        chk("hz_in_flight", {31'd0, bus.ld_hazard}, 32'd1);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        #1;
        chk("hz_after_ack", {31'd0, bus.ld_hazard}, 32'd0);
        bus.ld_valid = 1'b0;
        cyc();

        // asynchronous reset while busy with three entries
        for (int k = 0; k < 3; k++)
            do_store(c_SW, 32'h0000_7000 + 32'(4 * k), 32'h7000_0000 + 32'(k), 0, 0, '0, '0, '0);
        chk("rb_req_before", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rb_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rb_empty", {31'd0, bus.empty}, 32'd1);
        chk("rb_ready", {31'd0, bus.st_ready}, 32'd1);
        chk("rb_addr", bus.mem_addr, 32'd0);
        cyc();
        rst = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0000_7004;
        #1;
        chk("rb_stale_hazard", {31'd0, bus.ld_hazard}, 32'd0);
        bus.ld_valid = 1'b0;
        cyc();
        do_store(c_SB, 32'h0000_6001, 32'h0000_00CD, 0, 1, 32'h0000_6000, 32'hCDCD_CDCD, 4'b0010);
        cyc();
        chk("rb_restart_addr", bus.mem_addr, 32'h0000_6000);
        bus.mem_ack = 1'b1;
        cyc();
        bus.mem_ack = 1'b0;
        cyc();

        chk("end_empty", {31'd0, bus.empty}, 32'd1);
        chk("end_wr_queue", 32'(wr_q.size()), 32'd0);
        chk("end_mis_queue", 32'(mis_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dm_store_unit
`default_nettype wire
